// File: rtl/axi_pkg.sv
// AXI4 response codes and burst encodings shared by the SoC fabric.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/soc_pkg.sv
// SoC-level NoC widths, slave-port AXI bundles, memory map constants and FSM state types.
package soc_pkg;

   localparam int unsigned NOC_ADDR_WIDTH = 64;
   localparam int unsigned NOC_DATA_WIDTH = 64;
   localparam int unsigned NOC_S_ID_WIDTH = 4;

   localparam logic [63:0] MEM_BASE_ADDR  = 64'h0000_0000;
   localparam logic [63:0] MEM_SIZE_BYTES = 64'h0001_0000;

   typedef struct packed {
      logic [NOC_S_ID_WIDTH-1:0] id;
      logic [NOC_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
   } s_ax_t;

   typedef struct packed {
      logic [NOC_DATA_WIDTH-1:0]   data;
      logic [NOC_DATA_WIDTH/8-1:0] strb;
      logic                        last;
   } s_w_t;

   typedef struct packed {
      logic [NOC_S_ID_WIDTH-1:0] id;
      logic [1:0]                resp;
      logic                      user;
   } s_b_t;

   typedef struct packed {
      logic [NOC_S_ID_WIDTH-1:0] id;
      logic [NOC_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
      logic                      user;
   } s_r_t;

   typedef struct packed {
      s_ax_t aw;
      logic  aw_valid;
      s_w_t  w;
      logic  w_valid;
      logic  b_ready;
      s_ax_t ar;
      logic  ar_valid;
      logic  r_ready;
   } s_req_t;

   typedef struct packed {
      logic  aw_ready;
      logic  w_ready;
      logic  ar_ready;
      s_b_t  b;
      logic  b_valid;
      s_r_t  r;
      logic  r_valid;
   } s_resp_t;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/soc_axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP plus wrap-length legality.
module soc_axi_burst_addr_gen
   import soc_pkg::*;
   import axi_pkg::*;
(
   input  logic [NOC_ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]                len_i,
   input  logic [2:0]                size_i,
   input  logic [1:0]                burst_i,
   output logic [NOC_ADDR_WIDTH-1:0] next_addr_o,
   output logic                      wrap_ok_o
);

   localparam int unsigned AW = NOC_ADDR_WIDTH;

   logic [AW-1:0] step;
   logic [AW-1:0] window;
   logic [AW-1:0] wbase;
   logic [AW-1:0] incr_addr;

   always_comb begin
      step      = AW'(1) << size_i;
      window    = step * (AW'(len_i) + AW'(1));
      wbase     = addr_i & ~(window - AW'(1));
      incr_addr = (addr_i & ~(step - AW'(1))) + step;
      wrap_ok_o = wrap_len_ok(len_i);
      case (burst_i)
         BURST_INCR: next_addr_o = incr_addr;
         // illegal wrap lengths are errored; stepping linearly keeps the index sane
         BURST_WRAP: next_addr_o = wrap_ok_o ? (wbase | ((addr_i + step) & (window - AW'(1))))
                                             : incr_addr;
         default:    next_addr_o = addr_i;
      endcase
   end

endmodule

// File: rtl/soc_axi_mem_slave.sv
// AXI4 SRAM responder: independent write and read engines, one burst each, byte-enabled memory.
module soc_axi_mem_slave
   import soc_pkg::*;
   import axi_pkg::*;
#(
   parameter logic [63:0] MEM_BASE  = soc_pkg::MEM_BASE_ADDR,
   parameter logic [63:0] MEM_BYTES = soc_pkg::MEM_SIZE_BYTES,
   parameter type         req_t     = soc_pkg::s_req_t,
   parameter type         resp_t    = soc_pkg::s_resp_t
) (
   input  logic  clk_i,
   input  logic  arst_i,
   input  req_t  req_i,
   output resp_t resp_o
);

   localparam int unsigned AW      = NOC_ADDR_WIDTH;
   localparam int unsigned BW      = NOC_DATA_WIDTH / 8;
   localparam int unsigned BW_LOG2 = $clog2(BW);
   localparam int unsigned WORDS   = 32'(MEM_BYTES >> BW_LOG2);
   localparam int unsigned WIDX_W  = $clog2(WORDS);

   function automatic logic [WIDX_W-1:0] widx(input logic [AW-1:0] a);
      return WIDX_W'((a - MEM_BASE) >> BW_LOG2);
   endfunction

   function automatic logic [1:0] accept_resp(input logic [AW-1:0] a, input logic [2:0] size,
                                              input logic [1:0] burst, input logic wrap_ok);
      if ((a < MEM_BASE) || ((a - MEM_BASE) >= MEM_BYTES)) return RESP_DECERR;
      if ((size > 3'(BW_LOG2)) || ((burst == BURST_WRAP) && !wrap_ok)) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   logic [NOC_DATA_WIDTH-1:0] mem_q [WORDS];

   wr_state_e                 wstate_q, wstate_d;
   logic [NOC_S_ID_WIDTH-1:0] wid_q, wid_d;
   logic [AW-1:0]             waddr_q, waddr_d;
   logic [7:0]                wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic [2:0]                wsize_q, wsize_d;
   logic [1:0]                wburst_q, wburst_d, wresp_q, wresp_d, wbeat_resp;
   logic                      aw_ready, w_ready, b_valid, mem_we, w_idle;
   logic [WIDX_W-1:0]         mem_widx;
   logic [AW-1:0]             wg_next;
   logic                      wg_wrap_ok;

   rd_state_e                 rstate_q, rstate_d;
   logic [NOC_S_ID_WIDTH-1:0] rid_q, rid_d;
   logic [AW-1:0]             raddr_q, raddr_d;
   logic [7:0]                rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic [2:0]                rsize_q, rsize_d;
   logic [1:0]                rburst_q, rburst_d, rresp_q, rresp_d;
   logic [NOC_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      ar_ready, r_valid, r_last, r_idle;
   logic [AW-1:0]             rg_next;
   logic                      rg_wrap_ok;

   // In IDLE the generators see the incoming AW/AR so wrap legality is judged at acceptance.
   assign w_idle = (wstate_q == W_IDLE);
   assign r_idle = (rstate_q == R_IDLE);

   soc_axi_burst_addr_gen u_wr_addr_gen (
      .addr_i      (w_idle ? req_i.aw.addr  : waddr_q),
      .len_i       (w_idle ? req_i.aw.len   : wlen_q),
      .size_i      (w_idle ? req_i.aw.size  : wsize_q),
      .burst_i     (w_idle ? req_i.aw.burst : wburst_q),
      .next_addr_o (wg_next),
      .wrap_ok_o   (wg_wrap_ok)
   );

   soc_axi_burst_addr_gen u_rd_addr_gen (
      .addr_i      (r_idle ? req_i.ar.addr  : raddr_q),
      .len_i       (r_idle ? req_i.ar.len   : rlen_q),
      .size_i      (r_idle ? req_i.ar.size  : rsize_q),
      .burst_i     (r_idle ? req_i.ar.burst : rburst_q),
      .next_addr_o (rg_next),
      .wrap_ok_o   (rg_wrap_ok)
   );

   always_comb begin
      wstate_d   = wstate_q;
      wid_d      = wid_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wsize_d    = wsize_q;
      wburst_d   = wburst_q;
      wcnt_d     = wcnt_q;
      wresp_d    = wresp_q;
      wbeat_resp = wresp_q;
      aw_ready   = 1'b0;
      w_ready    = 1'b0;
      b_valid    = 1'b0;
      mem_we     = 1'b0;
      mem_widx   = widx(waddr_q);
      case (wstate_q)
         W_IDLE: begin
            aw_ready = !arst_i;
            if (req_i.aw_valid) begin
               wid_d    = req_i.aw.id;
               waddr_d  = req_i.aw.addr;
               wlen_d   = req_i.aw.len;
               wsize_d  = req_i.aw.size;
               wburst_d = req_i.aw.burst;
               wcnt_d   = '0;
               wresp_d  = accept_resp(req_i.aw.addr, req_i.aw.size, req_i.aw.burst, wg_wrap_ok);
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            w_ready = 1'b1;
            if (req_i.w_valid) begin
               // a last-flag mismatch errors this beat itself; DECERR still outranks it
               if (req_i.w.last != (wcnt_q == wlen_q))
                  wbeat_resp = (wresp_q == RESP_DECERR) ? RESP_DECERR : RESP_SLVERR;
               mem_we  = (wbeat_resp == RESP_OKAY);
               wresp_d = wbeat_resp;
               waddr_d = wg_next;
               wcnt_d  = wcnt_q + 8'd1;
               if (req_i.w.last || (wcnt_q == wlen_q)) wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (req_i.b_ready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Read data is captured at AR/beat handshake, so it holds while stalled and sees pre-write contents.
   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      raddr_d  = raddr_q;
      rlen_d   = rlen_q;
      rsize_d  = rsize_q;
      rburst_d = rburst_q;
      rcnt_d   = rcnt_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      r_last   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            ar_ready = !arst_i;
            if (req_i.ar_valid) begin
               rid_d    = req_i.ar.id;
               raddr_d  = req_i.ar.addr;
               rlen_d   = req_i.ar.len;
               rsize_d  = req_i.ar.size;
               rburst_d = req_i.ar.burst;
               rcnt_d   = '0;
               rresp_d  = accept_resp(req_i.ar.addr, req_i.ar.size, req_i.ar.burst, rg_wrap_ok);
               rdata_d  = (rresp_d == RESP_DECERR) ? '0 : mem_q[widx(req_i.ar.addr)];
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            r_valid = 1'b1;
            r_last  = (rcnt_q == rlen_q);
            if (req_i.r_ready) begin
               if (r_last) begin
                  rstate_d = R_IDLE;
               end else begin
                  raddr_d = rg_next;
                  rcnt_d  = rcnt_q + 8'd1;
                  rdata_d = (rresp_q == RESP_DECERR) ? '0 : mem_q[widx(rg_next)];
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wstate_q <= W_IDLE;
         wid_q    <= '0;
         waddr_q  <= '0;
         wlen_q   <= '0;
         wsize_q  <= '0;
         wburst_q <= '0;
         wcnt_q   <= '0;
         wresp_q  <= '0;
         rstate_q <= R_IDLE;
         rid_q    <= '0;
         raddr_q  <= '0;
         rlen_q   <= '0;
         rsize_q  <= '0;
         rburst_q <= '0;
         rcnt_q   <= '0;
         rresp_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wstate_q <= wstate_d;
         wid_q    <= wid_d;
         waddr_q  <= waddr_d;
         wlen_q   <= wlen_d;
         wsize_q  <= wsize_d;
         wburst_q <= wburst_d;
         wcnt_q   <= wcnt_d;
         wresp_q  <= wresp_d;
         rstate_q <= rstate_d;
         rid_q    <= rid_d;
         raddr_q  <= raddr_d;
         rlen_q   <= rlen_d;
         rsize_q  <= rsize_d;
         rburst_q <= rburst_d;
         rcnt_q   <= rcnt_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < BW; i++) begin
            if (req_i.w.strb[i]) mem_q[mem_widx][i*8 +: 8] <= req_i.w.data[i*8 +: 8];
         end
      end
   end

   always_comb begin
      resp_o          = '0;
      resp_o.aw_ready = aw_ready;
      resp_o.w_ready  = w_ready;
      resp_o.ar_ready = ar_ready;
      resp_o.b_valid  = b_valid;
      resp_o.b.id     = wid_q;
      resp_o.b.resp   = wresp_q;
      resp_o.b.user   = 1'b0;
      resp_o.r_valid  = r_valid;
      resp_o.r.id     = rid_q;
      resp_o.r.data   = rdata_q;
      resp_o.r.resp   = rresp_q;
      resp_o.r.last   = r_last;
      resp_o.r.user   = 1'b0;
   end

endmodule

// File: tb/tb_soc_axi_mem_slave.sv
// Directed bench for soc_axi_mem_slave: bursts, wrap, errors, strobes, reset abort, read-before-write.
module tb_soc_axi_mem_slave;
   import soc_pkg::*;
   import axi_pkg::*;

   logic    clk;
   logic    rst;
   s_req_t  req;
   s_resp_t resp;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   logic [63:0] wdata_v [16];
   logic [63:0] rdata_v [16];
   logic [1:0]  rresp_v [16];
   logic        rlast_v [16];
   logic [3:0]  rid_v   [16];
   int unsigned rbeats;

   soc_axi_mem_slave #(
      .MEM_BASE  (64'h0000_0000),
      .MEM_BYTES (64'h0001_0000),
      .req_t     (s_req_t),
      .resp_t    (s_resp_t)
   ) dut (
      .clk_i  (clk),
      .arst_i (rst),
      .req_i  (req),
      .resp_o (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic s_ax_t mk_ax(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                   input logic [1:0] burst);
      s_ax_t ax;
      ax.id    = id;
      ax.addr  = addr;
      ax.len   = len;
      ax.size  = 3'd3;
      ax.burst = burst;
      return ax;
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int unsigned nbeats, input logic [7:0] strb,
                           output logic [1:0] bresp);
      logic hs;
      req.aw       = mk_ax(id, addr, len, burst);
      req.aw_valid = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
         hs = resp.aw_ready;
         tick();
      end
      req.aw_valid = 1'b0;
      if (!hs) chk("aw_timeout", 64'd0, 64'd1);
      for (int unsigned b = 0; b < nbeats; b++) begin
         req.w.data  = wdata_v[b];
         req.w.strb  = strb;
         req.w.last  = (b == nbeats - 1);
         req.w_valid = 1'b1;
         hs = 1'b0;
         for (int k = 0; k < 20 && !hs; k++) begin
            hs = resp.w_ready;
            tick();
         end
         if (!hs) chk("w_timeout", 64'd0, 64'd1);
      end
      req.w_valid = 1'b0;
      req.w.last  = 1'b0;
      chk("b_latency", 64'(resp.b_valid), 64'd1);
      chk("b_id", 64'(resp.b.id), 64'(id));
      bresp       = resp.b.resp;
      req.b_ready = 1'b1;
      tick();
      req.b_ready = 1'b0;
      chk("b_drop", 64'(resp.b_valid), 64'd0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      logic hs;
      logic done;
      req.ar       = mk_ax(id, addr, len, burst);
      req.ar_valid = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
         hs = resp.ar_ready;
         tick();
      end
      req.ar_valid = 1'b0;
      if (!hs) chk("ar_timeout", 64'd0, 64'd1);
      chk("r_latency", 64'(resp.r_valid), 64'd1);
      req.r_ready = 1'b1;
      rbeats = 0;
      done   = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (resp.r_valid && rbeats < 16) begin
            rdata_v[rbeats] = resp.r.data;
            rresp_v[rbeats] = resp.r.resp;
            rlast_v[rbeats] = resp.r.last;
            rid_v[rbeats]   = resp.r.id;
            rbeats++;
            done = resp.r.last;
         end
         tick();
      end
      req.r_ready = 1'b0;
      if (!done) chk("r_last_timeout", 64'd0, 64'd1);
      chk("r_drop", 64'(resp.r_valid), 64'd0);
   endtask

   logic [1:0]  br;
   logic [63:0] exp4 [4];
   logic        hs_aw;
   logic        quiet;

   initial begin
      req = '0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
      chk("rst_w_ready",  64'(resp.w_ready),  64'd0);
      chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
      chk("rst_b_valid",  64'(resp.b_valid),  64'd0);
      chk("rst_r_valid",  64'(resp.r_valid),  64'd0);
      chk("rst_r_last",   64'(resp.r.last),   64'd0);
      rst = 1'b0;
      #1;
      chk("idle_aw_ready", 64'(resp.aw_ready), 64'd1);
      chk("idle_ar_ready", 64'(resp.ar_ready), 64'd1);

      // single beat
      wdata_v[0] = 64'hDEAD_BEEF_0123_4567;
      do_write(4'h3, 64'h100, 8'd0, BURST_INCR, 1, 8'hFF, br);
      chk("single_bresp", 64'(br), 64'(RESP_OKAY));
      do_read(4'h5, 64'h100, 8'd0, BURST_INCR);
      chk("single_beats", 64'(rbeats), 64'd1);
      chk("single_data", rdata_v[0], 64'hDEAD_BEEF_0123_4567);
      chk("single_rresp", 64'(rresp_v[0]), 64'(RESP_OKAY));
      chk("single_last", 64'(rlast_v[0]), 64'd1);
      chk("single_rid", 64'(rid_v[0]), 64'h5);

      // INCR 4 beats
      for (int i = 0; i < 4; i++) wdata_v[i] = 64'hA000_0000_0000_0000 + 64'(i) * 64'h1111;
      do_write(4'h7, 64'h200, 8'd3, BURST_INCR, 4, 8'hFF, br);
      chk("incr_bresp", 64'(br), 64'(RESP_OKAY));
      do_read(4'h9, 64'h200, 8'd3, BURST_INCR);
      chk("incr_beats", 64'(rbeats), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("incr_data", rdata_v[i], 64'hA000_0000_0000_0000 + 64'(i) * 64'h1111);
         chk("incr_last", 64'(rlast_v[i]), 64'(i == 3));
         chk("incr_rid", 64'(rid_v[i]), 64'h9);
      end

      // WRAP len=3 from 0x310: beats land at 0x310, 0x318, 0x300, 0x308
      for (int i = 0; i < 4; i++) wdata_v[i] = 64'hD0D0_0000_0000_0000 + 64'(i);
      do_write(4'h1, 64'h310, 8'd3, BURST_WRAP, 4, 8'hFF, br);
      chk("wrap_bresp", 64'(br), 64'(RESP_OKAY));
      exp4[0] = 64'hD0D0_0000_0000_0002;
      exp4[1] = 64'hD0D0_0000_0000_0003;
      exp4[2] = 64'hD0D0_0000_0000_0000;
      exp4[3] = 64'hD0D0_0000_0000_0001;
      do_read(4'h2, 64'h300, 8'd3, BURST_INCR);
      for (int i = 0; i < 4; i++) chk("wrap_linear_data", rdata_v[i], exp4[i]);
      do_read(4'h2, 64'h310, 8'd3, BURST_WRAP);
      for (int i = 0; i < 4; i++) chk("wrap_read_data", rdata_v[i], 64'hD0D0_0000_0000_0000 + 64'(i));

      // WRAP len=2 is illegal
      for (int i = 0; i < 3; i++) wdata_v[i] = 64'hBAD0_BAD0_BAD0_BAD0;
      do_write(4'h4, 64'h310, 8'd2, BURST_WRAP, 3, 8'hFF, br);
      chk("wrap2_bresp", 64'(br), 64'(RESP_SLVERR));
      do_read(4'h4, 64'h310, 8'd2, BURST_WRAP);
      chk("wrap2_beats", 64'(rbeats), 64'd3);
      for (int i = 0; i < 3; i++) chk("wrap2_rresp", 64'(rresp_v[i]), 64'(RESP_SLVERR));
      do_read(4'h4, 64'h310, 8'd0, BURST_INCR);
      chk("wrap2_suppressed", rdata_v[0], 64'hD0D0_0000_0000_0000);

      // DECERR just past the end; word 0 would alias if the index were not guarded
      wdata_v[0] = 64'h0F0F_0F0F_1234_5678;
      do_write(4'h0, 64'h0, 8'd0, BURST_INCR, 1, 8'hFF, br);
      do_read(4'h6, 64'h1_0000, 8'd0, BURST_INCR);
      chk("dec_rresp", 64'(rresp_v[0]), 64'(RESP_DECERR));
      chk("dec_rdata", rdata_v[0], 64'd0);
      wdata_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(4'h6, 64'h1_0000, 8'd0, BURST_INCR, 1, 8'hFF, br);
      chk("dec_bresp", 64'(br), 64'(RESP_DECERR));
      do_read(4'h6, 64'h0, 8'd0, BURST_INCR);
      chk("dec_mem_kept", rdata_v[0], 64'h0F0F_0F0F_1234_5678);

      // early w.last on beat 1 of a 4-beat burst
      wdata_v[0] = 64'h1234_1234_1234_1234;
      wdata_v[1] = 64'h5678_5678_5678_5678;
      do_write(4'hA, 64'h400, 8'd3, BURST_INCR, 2, 8'hFF, br);
      chk("early_last_bresp", 64'(br), 64'(RESP_SLVERR));
      do_read(4'hA, 64'h400, 8'd0, BURST_INCR);
      chk("early_last_beat0", rdata_v[0], 64'h1234_1234_1234_1234);

      // partial strobe
      wdata_v[0] = 64'h1111_2222_3333_4444;
      do_write(4'hB, 64'h500, 8'd0, BURST_INCR, 1, 8'hFF, br);
      wdata_v[0] = 64'hAAAA_BBBB_CCCC_DDDD;
      do_write(4'hB, 64'h500, 8'd0, BURST_INCR, 1, 8'h0F, br);
      do_read(4'hB, 64'h500, 8'd0, BURST_INCR);
      chk("strb_merge", rdata_v[0], 64'h1111_2222_CCCC_DDDD);

      // AR handshake on the same edge as the W beat to the same word
      wdata_v[0] = 64'h5555_5555_5555_5555;
      do_write(4'hC, 64'h600, 8'd0, BURST_INCR, 1, 8'hFF, br);
      req.aw       = mk_ax(4'h2, 64'h600, 8'd0, BURST_INCR);
      req.aw_valid = 1'b1;
      hs_aw        = resp.aw_ready;
      tick();
      req.aw_valid = 1'b0;
      chk("rbw_aw_hs", 64'(hs_aw), 64'd1);
      req.w.data   = 64'h9999_8888_7777_6666;
      req.w.strb   = 8'hFF;
      req.w.last   = 1'b1;
      req.w_valid  = 1'b1;
      req.ar       = mk_ax(4'h4, 64'h600, 8'd0, BURST_INCR);
      req.ar_valid = 1'b1;
      chk("rbw_readys", 64'({resp.w_ready, resp.ar_ready}), 64'd3);
      tick();
      req.w_valid  = 1'b0;
      req.w.last   = 1'b0;
      req.ar_valid = 1'b0;
      chk("rbw_r_valid", 64'(resp.r_valid), 64'd1);
      chk("rbw_old_data", resp.r.data, 64'h5555_5555_5555_5555);
      tick();
      chk("rbw_stall_stable", resp.r.data, 64'h5555_5555_5555_5555);
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
      tick();
      req.b_ready = 1'b0;
      req.r_ready = 1'b0;
      do_read(4'h4, 64'h600, 8'd0, BURST_INCR);
      chk("rbw_new_data", rdata_v[0], 64'h9999_8888_7777_6666);

      // reset while beat 2 of 4 is pending
      req.ar       = mk_ax(4'hD, 64'h200, 8'd3, BURST_INCR);
      req.ar_valid = 1'b1;
      tick();
      req.ar_valid = 1'b0;
      req.r_ready  = 1'b1;
      tick();
      tick();
      chk("abort_beat2_valid", 64'(resp.r_valid), 64'd1);
      chk("abort_beat2_data", resp.r.data, 64'hA000_0000_0000_2222);
      rst = 1'b1;
      #1;
      chk("abort_r_valid", 64'(resp.r_valid), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      req.b_ready = 1'b1;
      quiet = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (resp.r_valid || resp.b_valid) quiet = 1'b0;
         tick();
      end
      req.r_ready = 1'b0;
      req.b_ready = 1'b0;
      chk("abort_quiet", 64'(quiet), 64'd1);
      do_read(4'hE, 64'h100, 8'd0, BURST_INCR);
      chk("abort_next_data", rdata_v[0], 64'hDEAD_BEEF_0123_4567);
      chk("abort_next_rid", 64'(rid_v[0]), 64'hE);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
